// File: rtl/rv32_pkg.sv
// rv32_pkg: constants and encodings shared by the RV32 front-end stages.
// Holds the NOP used to fill an empty decode slot, the default reset PC,
// the fetch FSM state encoding and a word-alignment helper.
package rv32_pkg;

   // addi x0,x0,0 -- shown to decode whenever no valid instruction is held
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   // REQ: request pending; WAIT: granted, awaiting response;
   // DRAIN: granted request was killed, its response will be thrown away
   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   // Force an address down to a 4-byte boundary
   function automatic logic [31:0] align_word(input logic [31:0] i_addr);
      return {i_addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter for the fetch stage. Holds the PC, advances it
// by 4 when a request is issued, and loads a word-aligned redirect target.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, a
// redirect whose target has nonzero low bits raises o_misalign for exactly
// the following cycle; otherwise o_misalign is tied low.
module fetch_pc
   import rv32_pkg::*;
#(
   parameter logic [31:0] P_RESET_PC = RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_advance,
   input  logic        i_redirect,
   input  logic [31:0] i_target,
   output logic [31:0] o_pc,
   output logic        o_misalign
);

   logic [31:0] r_pc;

   // PC register: redirect wins over the sequential +4 step (wraps mod 2^32)
   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= P_RESET_PC;
      end else if (i_redirect) begin
         r_pc <= align_word(i_target);
      end else if (i_advance) begin
         r_pc <= r_pc + 32'd4;
      end
   end

   assign o_pc = r_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic r_misalign;

   // Misalignment flag: one-cycle pulse after a redirect to an unaligned target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= i_redirect && (i_target[1:0] != 2'b00);
      end
   end

   assign o_misalign = r_misalign;
`else
   // Low target bits are dropped silently when the check is compiled out
   logic w_unused_target_lsbs;
   assign w_unused_target_lsbs = ^i_target[1:0];
   assign o_misalign           = 1'b0;
`endif

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction-fetch stage feeding decode_ctl.
// Issues one instruction-memory request at a time, holds the returned word
// and its PC in a valid/ready output register, and applies execute-stage
// redirects, draining any wrong-path response still in flight.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (see fetch_pc).
module fetch_stage
   import rv32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_sel,
   input  logic [31:0] pc_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_dec,
   output logic [31:0] pc_dec,
   output logic        valid_dec,
   input  logic        ready_dec,
   output logic        misalign_err
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;

   logic [31:0] r_req_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc_dec;
   logic        r_valid;

   logic [31:0] w_pc;
   logic        w_misalign;
   logic        w_issue;
   logic        w_advance;
   logic        w_load;

   // A request may only go out when the output slot is empty or emptying now
   assign imem_req  = (r_state == ST_REQ) && (!r_valid || ready_dec);
   assign w_issue   = imem_req && imem_gnt;
   // A grant coinciding with a redirect is wrong-path: PC takes the target
   assign w_advance = w_issue && !pc_sel;
   // A response arriving with a redirect is discarded
   assign w_load    = (r_state == ST_WAIT) && imem_rvalid && !pc_sel;

   fetch_pc u_fetch_pc (
      .clk        (clk),
      .rst        (rst),
      .i_advance  (w_advance),
      .i_redirect (pc_sel),
      .i_target   (pc_target),
      .o_pc       (w_pc),
      .o_misalign (w_misalign)
   );

   // Next-state logic for the single-outstanding-request fetch FSM
   // NOTE: the next state is defaulted to the current one before the case so
   // that no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_REQ: begin
            if (w_issue) begin
               w_state_nxt = pc_sel ? ST_DRAIN : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               w_state_nxt = ST_REQ;
            end else if (pc_sel) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (imem_rvalid) begin
               w_state_nxt = ST_REQ;
            end
         end
         default: w_state_nxt = ST_REQ;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_REQ;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Remember the address of the request in flight to tag its response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_pc <= 32'h0;
      end else if (w_advance) begin
         r_req_pc <= w_pc;
      end
   end

   // Decode output register: redirect flush, then load, then consumption
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_instr  <= NOP_INSTR;
         r_pc_dec <= 32'h0;
      end else if (pc_sel) begin
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
      end else if (w_load) begin
         r_valid  <= 1'b1;
         r_instr  <= imem_rdata;
         r_pc_dec <= r_req_pc;
      end else if (r_valid && ready_dec) begin
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
      end
   end

   assign imem_addr    = w_pc;
   assign instr_dec    = r_instr;
   assign pc_dec       = r_pc_dec;
   assign valid_dec    = r_valid;
   assign misalign_err = w_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage. A behavioural
// instruction memory answers grants after a programmable latency; each test
// pushes the instructions decode must see onto a scoreboard queue, and a
// monitor pops and compares them as decode accepts them.
module tb_fetch_stage;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_sel;
   logic [31:0] pc_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr_dec;
   logic [31:0] pc_dec;
   logic        valid_dec;
   logic        ready_dec;
   logic        misalign_err;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] gnt_addr_q[$];
   int          gnt_cyc_q[$];
   int          acc_cyc_q[$];

   int          checks      = 0;
   int          failures    = 0;
   int          cyc         = 0;
   int          gnt_budget  = 0;
   int          mem_lat     = 1;
   bit          mem_pending = 1'b0;
   int          mem_cnt     = 0;
   logic [31:0] mem_addr    = 32'h0;

`ifdef FETCH_MISALIGN_CHECK_EN
   localparam logic EXP_MISALIGN = 1'b1;
`else
   localparam logic EXP_MISALIGN = 1'b0;
`endif

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .pc_sel       (pc_sel),
      .pc_target    (pc_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instr_dec    (instr_dec),
      .pc_dec       (pc_dec),
      .valid_dec    (valid_dec),
      .ready_dec    (ready_dec),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   // Memory contents: a distinct word per address, never equal to the NOP
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0] ^ 16'h8000};
   endfunction

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = mem_word(pc);
      exp_q.push_back(e);
   endtask

   // Memory drive at the falling edge, sampling/monitor just before rising edge
   always begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (rst) begin
         mem_pending = 1'b0;
      end else if (mem_pending) begin
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
            mem_pending = 1'b0;
         end else begin
            mem_cnt = mem_cnt - 1;
         end
      end
      imem_gnt = (gnt_budget > 0) && !mem_pending;
      #4;
      cyc = cyc + 1;
      if (!rst) begin
         if (imem_req && imem_gnt) begin
            mem_pending = 1'b1;
            mem_cnt     = mem_lat - 1;
            mem_addr    = imem_addr;
            gnt_budget  = gnt_budget - 1;
            gnt_addr_q.push_back(imem_addr);
            gnt_cyc_q.push_back(cyc);
         end
         if (!valid_dec) begin
            checks++;
            if (instr_dec !== NOP_INSTR) begin
               failures++;
               $display("FAIL nop_when_invalid: instr_dec=%h expected %h", instr_dec, NOP_INSTR);
            end
         end
         if (valid_dec && ready_dec) begin
            acc_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output: pc_dec=%h instr_dec=%h expected nothing", pc_dec, instr_dec);
            end else begin
               mon_e = exp_q.pop_front();
               if (pc_dec !== mon_e.pc || instr_dec !== mon_e.instr) begin
                  failures++;
                  $display("FAIL decode_output: pc_dec=%h instr_dec=%h expected pc %h instr %h",
                           pc_dec, instr_dec, mon_e.pc, mon_e.instr);
               end
            end
         end
      end
   end

   task automatic clear_logs();
      exp_q.delete();
      gnt_addr_q.delete();
      gnt_cyc_q.delete();
      acc_cyc_q.delete();
   endtask

   // Reset with a grant budget/latency, released on a falling edge
   task automatic do_reset(input int budget, input int lat, input logic rdy);
      @(negedge clk);
      rst        = 1'b1;
      pc_sel     = 1'b0;
      pc_target  = 32'h0;
      ready_dec  = rdy;
      gnt_budget = budget;
      mem_lat    = lat;
      repeat (2) @(negedge clk);
      clear_logs();
      rst = 1'b0;
   endtask

   // Wait for the scoreboard to empty, then idle so stray outputs are caught
   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout: %0d outputs still pending, expected 0", name, exp_q.size());
      end
      repeat (6) @(negedge clk);
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      pc_sel    = 1'b0;
      pc_target = 32'h0;
      ready_dec = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (valid_dec !== 1'b0 || instr_dec !== NOP_INSTR || pc_dec !== 32'h0 ||
          imem_addr !== RESET_PC || misalign_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: valid=%b instr=%h pc_dec=%h addr=%h mis=%b expected 0 %h 0 %h 0",
                  valid_dec, instr_dec, pc_dec, imem_addr, misalign_err, NOP_INSTR, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      do_reset(3, 1, 1'b1);
      push_exp(32'h0);
      push_exp(32'h4);
      push_exp(32'h8);
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
         failures++;
         $display("FAIL first_request: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
      end
      wait_drain("sequential");
      checks++;
      if (gnt_addr_q.size() != 3 || acc_cyc_q.size() != 3) begin
         failures++;
         $display("FAIL seq_counts: grants=%0d accepts=%0d expected 3 3", gnt_addr_q.size(), acc_cyc_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (gnt_addr_q[i] !== 32'(4 * i) || acc_cyc_q[i] - gnt_cyc_q[i] != 2) begin
               failures++;
               $display("FAIL seq_timing[%0d]: addr=%h latency=%0d expected %h 2",
                        i, gnt_addr_q[i], acc_cyc_q[i] - gnt_cyc_q[i], 32'(4 * i));
            end
            if (i > 0) begin
               checks++;
               if (gnt_cyc_q[i] - gnt_cyc_q[i-1] != 2) begin
                  failures++;
                  $display("FAIL seq_spacing[%0d]: gap=%0d expected 2", i, gnt_cyc_q[i] - gnt_cyc_q[i-1]);
               end
            end
         end
      end
   endtask

   task automatic test_stall();
      int n;
      do_reset(3, 1, 1'b0);
      push_exp(32'h0);
      push_exp(32'h4);
      push_exp(32'h8);
      n = 0;
      while (!valid_dec && n < 20) begin @(negedge clk); n++; end
      ready_dec = 1'b1;
      @(negedge clk);
      ready_dec = 1'b0;
      n = 0;
      while (!(valid_dec && pc_dec == 32'h4) && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (!(valid_dec && pc_dec == 32'h4)) begin
         failures++;
         $display("FAIL stall_setup: valid=%b pc_dec=%h expected 1 00000004", valid_dec, pc_dec);
      end
      repeat (4) begin
         @(negedge clk);
         #1;
         checks++;
         if (imem_req !== 1'b0 || valid_dec !== 1'b1 || instr_dec !== mem_word(32'h4)) begin
            failures++;
            $display("FAIL stall_hold: req=%b valid=%b instr=%h expected 0 1 %h",
                     imem_req, valid_dec, instr_dec, mem_word(32'h4));
         end
      end
      @(negedge clk);
      ready_dec = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
         failures++;
         $display("FAIL stall_release: req=%b addr=%h expected 1 00000008", imem_req, imem_addr);
      end
      wait_drain("stall");
   endtask

   task automatic test_redirect_wait();
      int n = 0;
      do_reset(5, 3, 1'b1);
      push_exp(32'h0);
      push_exp(32'h4);
      push_exp(32'h100);
      push_exp(32'h104);
      while (gnt_addr_q.size() < 3 && n < 40) begin @(negedge clk); n++; end
      pc_sel    = 1'b1;
      pc_target = 32'h100;
      @(negedge clk);
      pc_sel = 1'b0;
      #1;
      checks++;
      if (imem_addr !== 32'h100 || imem_req !== 1'b0) begin
         failures++;
         $display("FAIL redirect_wait_drain: addr=%h req=%b expected 00000100 0", imem_addr, imem_req);
      end
      wait_drain("redirect_wait");
      checks++;
      if (gnt_addr_q.size() != 5 || gnt_addr_q[2] !== 32'h8 || gnt_addr_q[3] !== 32'h100) begin
         failures++;
         $display("FAIL redirect_wait_grants: count=%0d expected 5 with 00000008 then 00000100", gnt_addr_q.size());
      end
   endtask

   task automatic test_redirect_grant();
      int n = 0;
      do_reset(6, 1, 1'b1);
      push_exp(32'h0);
      push_exp(32'h4);
      push_exp(32'h8);
      push_exp(32'h200);
      push_exp(32'h204);
      @(negedge clk);
      #1;
      while (!(imem_req && imem_addr == 32'hC) && n < 40) begin @(negedge clk); #1; n++; end
      pc_sel    = 1'b1;
      pc_target = 32'h200;
      @(negedge clk);
      pc_sel = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h200) begin
         failures++;
         $display("FAIL redirect_grant_drain: req=%b addr=%h expected 0 00000200", imem_req, imem_addr);
      end
      wait_drain("redirect_grant");
      checks++;
      if (gnt_addr_q.size() != 6 || gnt_addr_q[3] !== 32'hC || gnt_addr_q[4] !== 32'h200) begin
         failures++;
         $display("FAIL redirect_grant_grants: count=%0d expected 6 with 0000000c then 00000200", gnt_addr_q.size());
      end
   endtask

   task automatic test_misalign();
      do_reset(0, 1, 1'b1);
      @(negedge clk);
      pc_sel    = 1'b1;
      pc_target = 32'h102;
      @(negedge clk);
      pc_sel = 1'b0;
      #1;
      checks++;
      if (imem_addr !== 32'h100 || misalign_err !== EXP_MISALIGN) begin
         failures++;
         $display("FAIL misalign_pulse: addr=%h err=%b expected 00000100 %b", imem_addr, misalign_err, EXP_MISALIGN);
      end
      @(negedge clk);
      #1;
      checks++;
      if (misalign_err !== 1'b0) begin
         failures++;
         $display("FAIL misalign_clear: err=%b expected 0", misalign_err);
      end
      pc_sel    = 1'b1;
      pc_target = 32'h104;
      @(negedge clk);
      pc_sel = 1'b0;
      #1;
      checks++;
      if (imem_addr !== 32'h104 || misalign_err !== 1'b0) begin
         failures++;
         $display("FAIL aligned_redirect: addr=%h err=%b expected 00000104 0", imem_addr, misalign_err);
      end
      gnt_budget = 1;
      push_exp(32'h104);
      wait_drain("misalign");
   endtask

   task automatic test_reset_mid();
      int n = 0;
      do_reset(3, 5, 1'b1);
      push_exp(32'h0);
      push_exp(32'h4);
      while (gnt_addr_q.size() < 3 && n < 60) begin @(negedge clk); n++; end
      rst = 1'b1;
      #1;
      checks++;
      if (valid_dec !== 1'b0 || instr_dec !== NOP_INSTR || pc_dec !== 32'h0 ||
          imem_addr !== RESET_PC || misalign_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: valid=%b instr=%h pc_dec=%h addr=%h mis=%b expected 0 %h 0 %h 0",
                  valid_dec, instr_dec, pc_dec, imem_addr, misalign_err, NOP_INSTR, RESET_PC);
      end
      repeat (2) @(negedge clk);
      clear_logs();
      gnt_budget = 1;
      mem_lat    = 1;
      push_exp(RESET_PC);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
         failures++;
         $display("FAIL reset_mid_restart: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
      end
      wait_drain("reset_mid");
   endtask

   task automatic test_wrap();
      do_reset(0, 1, 1'b1);
      @(negedge clk);
      pc_sel    = 1'b1;
      pc_target = 32'hFFFF_FFFC;
      @(negedge clk);
      pc_sel = 1'b0;
      push_exp(32'hFFFF_FFFC);
      push_exp(32'h0000_0000);
      gnt_budget = 2;
      wait_drain("wrap");
      checks++;
      if (gnt_addr_q.size() != 2 || gnt_addr_q[0] !== 32'hFFFF_FFFC || gnt_addr_q[1] !== 32'h0) begin
         failures++;
         $display("FAIL wrap_grants: count=%0d expected 2 with fffffffc then 00000000", gnt_addr_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      do_reset(24, 1, 1'b1);
      for (int i = 0; i < 24; i++) push_exp(32'(4 * i));
      while (exp_q.size() != 0 && n < 600) begin
         @(negedge clk);
         ready_dec = 1'($urandom_range(0, 1));
         mem_lat   = int'($urandom_range(1, 3));
         n++;
      end
      ready_dec = 1'b1;
      wait_drain("back_to_back");
      checks++;
      if (gnt_addr_q.size() != 24) begin
         failures++;
         $display("FAIL back_to_back_grants: count=%0d expected 24", gnt_addr_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_grant();
      test_misalign();
      test_reset_mid();
      test_wrap();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction-fetch stage of the RV32 pipeline, sitting directly upstream of `decode_ctl`.
- Owns the program counter and issues one instruction-memory request at a time.
- Holds each returned instruction with its PC in an output register, under valid/ready handshake with decode.
- Applies branch/jump redirects (`pc_sel`/`pc_target`) from the execute stage, discarding wrong-path fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, value driven on `instr_dec` while `valid_dec` is low (`addi x0,x0,0`).

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc_sel` in 1: redirect strobe from execute, one-cycle pulse.
- `pc_target` in 32: redirect address, sampled when `pc_sel`=1.
- `imem_req` out 1: instruction memory request.
- `imem_addr` out 32: request address; stable while `imem_req`=1 and `imem_gnt`=0.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid; arrives ≥1 cycle after grant.
- `imem_rdata` in 32: response instruction word.
- `instr_dec` out 32: instruction to decode.
- `pc_dec` out 32: PC of `instr_dec`.
- `valid_dec` out 1: output register holds a valid instruction.
- `ready_dec` in 1: decode accepts `instr_dec` this cycle.
- `misalign_err` out 1: misaligned redirect target (see Configuration).

## Operation
- States: REQ (request pending), WAIT (granted, awaiting response), DRAIN (granted request was killed, awaiting its response to discard).
- REQ:
  - `imem_req` = `!valid_dec || ready_dec`, with `imem_addr` = pc.
  - On `imem_req && imem_gnt`: latch `req_pc` <= pc, pc <= pc+4 (mod 2^32, wraps FFFF_FFFC→0000_0000), go WAIT.
- WAIT:
  - On `imem_rvalid`: `instr_dec` <= `imem_rdata`, `pc_dec` <= `req_pc`, `valid_dec` <= 1, go REQ.
  - The output register is always free here because issue required it to be free or draining.
- DRAIN: on `imem_rvalid`, discard the data, go REQ. `imem_req`=0.
- Handshake: `valid_dec` clears on `valid_dec && ready_dec` unless reloaded the same cycle. `instr_dec` = `NOP_INSTR` whenever `valid_dec`=0.
- Redirect (`pc_sel`=1) has priority over everything:
  - pc <= {`pc_target`[31:2],2'b00}; `valid_dec` <= 0 (flush, regardless of `ready_dec`).
  - In REQ with a grant the same cycle: the granted request is wrong-path, go DRAIN.
  - In REQ without a grant: stay REQ, and no request is issued that cycle.
  - In WAIT without `imem_rvalid`: go DRAIN.
  - In WAIT with `imem_rvalid`: discard the data, go REQ.
  - In DRAIN: stay DRAIN, or go REQ if `imem_rvalid`.
- Reset (async, any state, mid-transaction): pc=`RESET_PC`, state=REQ, `valid_dec`=0, `instr_dec`=`NOP_INSTR`, `pc_dec`=0, `req_pc`=0, `misalign_err`=0.
  - The memory must also be reset. Responses to pre-reset grants are undefined.

## Timing
- First `imem_req` in the first cycle after `rst` deasserts.
- Grant in cycle N, `imem_rvalid` in cycle N+k (k≥1) → `valid_dec`=1 from cycle N+k+1.
- At most one outstanding request. Peak throughput is one instruction per 2 cycles (gnt in REQ, rvalid next cycle).
- Redirect in cycle N → `imem_addr`=target from cycle N+1, once state is REQ.
- All outputs are registered except `imem_req`, which is combinational from state, `valid_dec` and `ready_dec`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `pc_target[1:0]`≠0 pulses `misalign_err`=1 for exactly the following cycle. The target is still aligned down.
- `FETCH_MISALIGN_CHECK_EN` undefined: `misalign_err` is tied 0 and alignment is silent.

## Structure
- Shared package `rv32_pkg` holds:
  - the `NOP_INSTR` constant and the default `RESET_PC`;
  - the fetch state encoding (REQ/WAIT/DRAIN, 2-bit).
- One sub-module, `fetch_pc`: the PC register, +4 incrementer and redirect/alignment mux. It outputs pc and the misalignment flag.

## Test plan
- Reset release with memory always granting, rvalid 1 cycle later, `ready_dec`=1 → `imem_addr` 0x0, 0x4, 0x8 on alternate cycles. `pc_dec` follows 2 cycles later with the matching `imem_rdata`.
- Hold `ready_dec`=0 with `valid_dec`=1 at pc_dec 0x4 → `imem_req` stays 0 and `instr_dec` is stable. Raise `ready_dec` → fetch of 0x8 issues the same cycle.
- `pc_sel`=1, target 0x100, during WAIT for 0x8 → 0x8 response discarded, next `imem_addr`=0x100, `pc_dec` never shows 0x8.
- `pc_sel`=1, target 0x200, in the same cycle as grant for 0xC → state DRAIN. The 0xC data is dropped, then request 0x200.
- Redirect target 0x102 → `imem_addr` 0x100. With the macro, `misalign_err` pulses 1 cycle; without it, it stays 0.
- Assert `rst` mid-WAIT → all outputs return to reset values immediately. After release the first request is `RESET_PC`.
- Redirect target 0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000.
